// File: rtl/i_mem_pkg.sv
// Shared constants and types for the pipelined instruction memory.
// Optional parity support is selected with the I_MEM_PARITY_EN macro.
package i_mem_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;

    // Canonical 32-bit fetch tag; the pipe carries the same fields at BUS_WIDTH.
    typedef struct packed {
        logic        valid;
        logic        fault;
        logic [31:0] data;
    } fetch_tag_t;

    function automatic logic [1:0] size_align_mask(input size_e sz);
        case (sz)
            SIZE_WORD: return 2'b11;
            SIZE_HALF: return 2'b01;
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/i_mem_array.sv
// Instruction storage: synchronous write, combinational read.
// With I_MEM_PARITY_EN each word keeps an even-parity bit checked on read.
module i_mem_array
    import i_mem_pkg::*;
#(
    parameter int BUS_WIDTH   = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic [BUS_WIDTH-1:0] wr_data_i,
    input  logic [IDX_W-1:0]     rd_idx_i,
    output logic [BUS_WIDTH-1:0] rd_data_o
`ifdef I_MEM_PARITY_EN
    ,
    output logic                 rd_par_err_o
`endif
);

    logic [BUS_WIDTH-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

`ifdef I_MEM_PARITY_EN
    logic par_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            par_q[wr_idx_i] <= ^wr_data_i;
        end
    end

    assign rd_par_err_o = (^rd_data_o) ^ par_q[rd_idx_i];
`endif

endmodule

// File: rtl/i_mem_pipe.sv
// Instruction memory with fetch handshake, RD_LATENCY-deep read pipeline,
// program-load port and fault reporting. Optional parity: I_MEM_PARITY_EN.
module i_mem_pipe
    import i_mem_pkg::*;
#(
    parameter int BUS_WIDTH   = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_req,
    input  logic [BUS_WIDTH-1:0] fetch_addr,
    output logic                 fetch_ready,
    input  logic                 flush,
    output logic [BUS_WIDTH-1:0] inst,
    output logic                 inst_valid,
    output logic                 fetch_fault,
    input  logic                 ld_en,
    input  logic [BUS_WIDTH-1:0] ld_addr,
    input  logic [BUS_WIDTH-1:0] ld_data,
    output logic                 ld_err
`ifdef I_MEM_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [BUS_WIDTH-1:0] NOP_W = BUS_WIDTH'(NOP_INST);

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("i_mem_pipe: RD_LATENCY must be within 1..4");
    end
    if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("i_mem_pipe: DEPTH_WORDS must be a power of two, at least 4");
    end
    if (BUS_WIDTH < IDX_W + 2) begin : g_bad_width
        $error("i_mem_pipe: BUS_WIDTH too narrow for DEPTH_WORDS");
    end

    typedef struct packed {
        logic                 valid;
        logic                 fault;
`ifdef I_MEM_PARITY_EN
        logic                 perr;
`endif
        logic [BUS_WIDTH-1:0] data;
    } tag_t;

    function automatic logic addr_legal(input logic [BUS_WIDTH-1:0] a);
        return ((a[1:0] & size_align_mask(SIZE_WORD)) == 2'b00) &&
               ((a >> (IDX_W + 2)) == '0);
    endfunction

    logic                 fetch_acc;
    logic                 fetch_legal;
    logic                 ld_legal;
    logic                 ld_wr;
    logic                 par_bad;
    logic                 out_vld;
    logic [BUS_WIDTH-1:0] rd_data;
    logic                 ld_err_d, ld_err_q;
    tag_t                 stage_d [RD_LATENCY];
    tag_t                 stage_q [RD_LATENCY];

    // Loads own the storage port for the cycle, so a fetch is held off.
    assign fetch_ready = !rst && !ld_en;
    assign fetch_acc   = fetch_req && fetch_ready;
    assign fetch_legal = addr_legal(fetch_addr);
    assign ld_legal    = addr_legal(ld_addr);
    assign ld_wr       = ld_en && ld_legal && !rst;
    assign ld_err_d    = ld_en && !ld_legal;

    i_mem_array #(
        .BUS_WIDTH   (BUS_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk          (clk),
        .wr_en_i      (ld_wr),
        .wr_idx_i     (ld_addr[IDX_W+1:2]),
        .wr_data_i    (ld_data),
        .rd_idx_i     (fetch_addr[IDX_W+1:2]),
        .rd_data_o    (rd_data)
`ifdef I_MEM_PARITY_EN
        ,
        .rd_par_err_o (par_bad)
`endif
    );

`ifndef I_MEM_PARITY_EN
    assign par_bad = 1'b0;
`endif

    always_comb begin
        // stage 0: tag built from the acceptance-cycle read
        stage_d[0].valid = fetch_acc;
        stage_d[0].fault = !fetch_legal || par_bad;
`ifdef I_MEM_PARITY_EN
        stage_d[0].perr  = fetch_legal && par_bad;
`endif
        stage_d[0].data  = (!fetch_legal || par_bad) ? NOP_W : rd_data;
        // stages 1..RD_LATENCY-1: shift, dropping older requests on flush
        for (int k = 1; k < RD_LATENCY; k++) begin
            stage_d[k]       = stage_q[k-1];
            stage_d[k].valid = stage_q[k-1].valid && !flush;
        end
    end

    always_ff @(posedge clk) begin
        stage_q  <= stage_d;
        ld_err_q <= ld_err_d;
        if (rst) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                stage_q[k].valid <= 1'b0;
            end
            ld_err_q <= 1'b0;
        end
    end

    // output: last stage, silenced while reset is held
    assign out_vld     = stage_q[RD_LATENCY-1].valid && !rst;
    assign inst_valid  = out_vld;
    assign inst        = out_vld ? stage_q[RD_LATENCY-1].data : NOP_W;
    assign fetch_fault = out_vld && stage_q[RD_LATENCY-1].fault;
    assign ld_err      = ld_err_q && !rst;
`ifdef I_MEM_PARITY_EN
    assign parity_err  = out_vld && stage_q[RD_LATENCY-1].perr;
`endif

endmodule

// File: doc/i_mem_pipe.md
Name: i_mem_pipe

Overview:
Parametrised instruction memory with a fetch handshake and a read pipeline of configurable latency. It also has a program-load write port and fault reporting for misaligned or out-of-range addresses. It sits between the fetch stage and instruction storage, and generalises the fixed word-size, zero-latency instruction memory. A flush input discards in-flight fetches on a control-flow redirect.

Parameters:
- BUS_WIDTH, 32, address and instruction width in bits.
- DEPTH_WORDS, 1024, number of words in storage. Must be a power of two, at least 4.
- RD_LATENCY, 1, cycles from fetch acceptance to response. Legal range 1..4; any other value is an elaboration error.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  BUS_WIDTH  byte address of the requested instruction.
- fetch_ready  out  1  fetch can be accepted this cycle.
- flush  in  1  discard all in-flight fetches.
- inst  out  BUS_WIDTH  fetched instruction.
- inst_valid  out  1  inst valid; high for one cycle per response.
- fetch_fault  out  1  the response carried by inst_valid is faulted.
- ld_en  in  1  program-load write strobe.
- ld_addr  in  BUS_WIDTH  load byte address.
- ld_data  in  BUS_WIDTH  load data.
- ld_err  out  1  the load issued in the previous cycle was rejected.

Behaviour:
- Word index = addr[log2(DEPTH_WORDS)+1 : 2].
- An address is legal iff addr[1:0]==0 and every address bit above the index is 0.
- fetch_ready = !rst && !ld_en. Loads have priority; a fetch is never accepted in a cycle with ld_en=1.
- Acceptance: fetch_req && fetch_ready in cycle N.
  - Storage is read combinationally in cycle N, so the response carries the contents as of cycle N.
  - The tag {valid, fault, data} enters stage 1 and shifts one stage per cycle.
  - inst_valid rises in cycle N+RD_LATENCY, for one cycle.
- One acceptance per cycle; throughput is 1 instruction/cycle. There is no output backpressure, so the consumer must sink every response.
- Fault on an illegal fetch address:
  - fetch_fault=1 alongside inst_valid=1.
  - inst = NOP (32'h0000_0013).
  - Storage is not read.
- When inst_valid=0: inst = NOP and fetch_fault=0.
- flush=1 in cycle F:
  - Every stage holding a request accepted before F is invalidated at the F edge; none of those responses ever appears.
  - A request accepted in cycle F itself is kept; it is the redirect target.
- Load in cycle N (ld_en=1):
  - Legal ld_addr: the word is written at the N edge and is visible to a fetch accepted in N+1.
  - Illegal ld_addr: the write is dropped and ld_err=1 in N+1 for one cycle.
- Loads do not disturb in-flight fetches. Those fetches return data sampled at their own acceptance.
- Reset, including mid-operation:
  - All pipeline stages are invalidated.
  - inst_valid=0, inst=NOP, fetch_fault=0, ld_err=0, fetch_ready=0 while rst=1.
  - Storage contents are preserved.
  - Fetch and load inputs are ignored while rst=1.
- Asserting flush and rst together behaves as reset.

Optional Feature:
I_MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on load.
  - Parity is checked at fetch acceptance.
  - A mismatch sets fetch_fault=1 and inst=NOP for that response.
  - An extra output parity_err (1 bit) pulses with inst_valid on a mismatch.
- Not defined: no parity storage and no parity_err port; a fault is alignment/range only.

Decomposition:
- Package i_mem_pkg holds:
  - NOP_INST = 32'h0000_0013;
  - WORD/HALF/BYTE size encodings (2'b10/2'b01/2'b00);
  - RD_LATENCY_MIN=1 and RD_LATENCY_MAX=4;
  - a fetch-tag struct {valid, fault, data}.
- One sub-module, i_mem_array, holds the storage: synchronous write, combinational read, and the parity bit under the macro.
- The pipeline, address checks and handshake stay in i_mem_pipe.

Test Plan:
- RD_LATENCY=2; load 0x100←0xDEAD_BEEF, then fetch 0x100 in cycle 10 → inst_valid=1 and inst=0xDEAD_BEEF in cycle 12 only, fetch_fault=0.
- Back-to-back fetches 0x0, 0x4, 0x8 in cycles 5–7 with RD_LATENCY=3 → valid responses in cycles 8–10, in order, with the matching data.
- Fetch 0x102, and fetch 0x1000 with DEPTH_WORDS=1024 → both return fetch_fault=1 and inst=0x0000_0013; load to 0x1001 → ld_err=1 the next cycle and the memory is unchanged.
- RD_LATENCY=3; fetches accepted in cycles 20 and 21, flush in cycle 22 together with a fetch of 0x40 → no responses for the first two; response for 0x40 in cycle 25.
- ld_en held in cycle 30 with fetch_req=1 → fetch_ready=0 and nothing accepted; fetch accepted in cycle 31 sees the newly loaded word.
- rst in cycle 15 with two fetches in flight → inst_valid stays 0 afterwards; a fetch after reset returns the word loaded before reset.
- With I_MEM_PARITY_EN: force a stored parity bit flip → parity_err=1, fetch_fault=1, inst=NOP.
